// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-8 Booth sequential multiplier.
package booth_pkg;

   // Controller states: wait for operands, build 3A, step digits, present result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Signed 3-bit digit type. A recoded digit's magnitude needs 0..4, so the
   // selector works with a sign flag plus magnitude rather than this type.
   typedef logic signed [2:0] digit_t;

   // Number of radix-8 digits: ceil((w+1)/3). The extra bit covers the sign
   // of an unsigned operand, so unsigned and signed share one datapath.
   function automatic int num_digits(input int w);
      return (w + 3) / 3;
   endfunction

endpackage

// File: rtl/booth_radix8_digit_sel.sv
// Combinational radix-8 Booth recoder and multiple selector.
// Takes one 4-bit group {b[3i+2], b[3i+1], b[3i], b[3i-1]} and returns d*A
// modulo 2^(2*WIDTH) in two's complement.
module booth_radix8_digit_sel
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         i_group,
   input  logic [2*WIDTH-1:0] i_a,
   input  logic [2*WIDTH-1:0] i_a3,
   output logic [2*WIDTH-1:0] o_mult
);

   logic             w_neg;
   logic [2:0]       w_mag;
   logic [2*WIDTH-1:0] w_pos;

   // Recode the group into sign and magnitude, then pick the matching multiple.
   always_comb begin
      w_neg = 1'b0;
      w_mag = 3'd0;
      case (i_group)
         4'b0000: begin w_neg = 1'b0; w_mag = 3'd0; end
         4'b0001: begin w_neg = 1'b0; w_mag = 3'd1; end
         4'b0010: begin w_neg = 1'b0; w_mag = 3'd1; end
         4'b0011: begin w_neg = 1'b0; w_mag = 3'd2; end
         4'b0100: begin w_neg = 1'b0; w_mag = 3'd2; end
         4'b0101: begin w_neg = 1'b0; w_mag = 3'd3; end
         4'b0110: begin w_neg = 1'b0; w_mag = 3'd3; end
         4'b0111: begin w_neg = 1'b0; w_mag = 3'd4; end
         4'b1000: begin w_neg = 1'b1; w_mag = 3'd4; end
         4'b1001: begin w_neg = 1'b1; w_mag = 3'd3; end
         4'b1010: begin w_neg = 1'b1; w_mag = 3'd3; end
         4'b1011: begin w_neg = 1'b1; w_mag = 3'd2; end
         4'b1100: begin w_neg = 1'b1; w_mag = 3'd2; end
         4'b1101: begin w_neg = 1'b1; w_mag = 3'd1; end
         4'b1110: begin w_neg = 1'b1; w_mag = 3'd1; end
         default: begin w_neg = 1'b0; w_mag = 3'd0; end
      endcase

      w_pos = '0;
      case (w_mag)
         3'd1:    w_pos = i_a;
         3'd2:    w_pos = i_a << 1;
         3'd3:    w_pos = i_a3;
         3'd4:    w_pos = i_a << 2;
         default: w_pos = '0;
      endcase

      o_mult = w_neg ? (~w_pos + {{(2*WIDTH-1){1'b0}}, 1'b1}) : w_pos;
   end

endmodule

// File: rtl/booth_radix8_seq_multiplier.sv
// Sequential radix-8 Booth multiplier: one digit per cycle, LSB digit first,
// signed or unsigned operands selected per transaction.
module booth_radix8_seq_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product
);

   localparam int ND    = num_digits(WIDTH);
   localparam int BW    = 3 * ND;
   localparam int CNT_W = $clog2(ND + 1);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(ND - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [2*WIDTH-1:0]   r_a;      // A, shifted left by 3 after each digit
   logic [2*WIDTH-1:0]   r_a3;     // 3A, shifted alongside r_a
   logic [2*WIDTH-1:0]   r_acc;
   logic [BW:0]          r_b;      // extended B with b[-1] in bit 0, shifted right by 3
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_accept;
   logic [2*WIDTH-1:0]   w_a_ext;
   logic [BW:0]          w_b_ext;
   logic [2*WIDTH-1:0]   w_mult;

   assign w_accept  = (r_state == ST_IDLE) && in_valid;
   assign w_a_ext   = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
   assign w_b_ext   = {{(BW-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign out_product = (r_state == ST_DONE) ? r_acc : '0;

   booth_radix8_digit_sel #(
      .WIDTH (WIDTH)
   ) u_digit_sel (
      .i_group (r_b[3:0]),
      .i_a     (r_a),
      .i_a3    (r_a3),
      .o_mult  (w_mult)
   );

   // State register; reset wins over everything including a same-edge accept.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid) w_state_next = ST_PRE;
         ST_PRE:  w_state_next = ST_RUN;
         ST_RUN:  if (r_cnt == LAST_DIGIT) w_state_next = ST_DONE;
         ST_DONE: if (out_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: capture operands, form 3A, then accumulate one digit per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_a3  <= '0;
         r_acc <= '0;
         r_b   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a   <= w_a_ext;
                  r_b   <= w_b_ext;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            ST_PRE: begin
               r_a3 <= r_a + (r_a << 1);
            end
            ST_RUN: begin
               r_acc <= r_acc + w_mult;
               r_a   <= r_a << 3;
               r_a3  <= r_a3 << 3;
               r_b   <= r_b >> 3;
               r_cnt <= r_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix8_seq_multiplier.sv
// Self-checking bench for booth_radix8_seq_multiplier at WIDTH=32.
module tb_booth_radix8_seq_multiplier;

   localparam int WIDTH = 32;
   localparam int ND    = (WIDTH + 3) / 3;   // ceil((WIDTH+1)/3)

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_signed;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_product;

   int n_total = 0;
   int n_bad   = 0;
   int n_txn   = 0;

   booth_radix8_seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_signed   (in_signed),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Reference: the exact mathematical product, reduced to 64 bits.
   function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa;
      longint sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Wait at a negedge until the block is ready; false if the bound expires.
   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      ok = in_ready;
   endtask

   task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
      int e;
      bit ok;
      logic [63:0] expp;
      logic [63:0] held;
      expp = ref_product(a, b, s);
      wait_ready(ok);
      if (!ok) begin
         check_val("ready_timeout", 64'd0, 64'd1);
         return;
      end
      in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
      tick();                                   // accept edge 0
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom_range(0, 1));
      check_val("busy_ready", 64'(in_ready), 64'd0);
      e = 0;
      while (!out_valid && e < 40) begin
         tick();
         e++;
         if (e == 5) check_val("busy_prod_zero", out_product, 64'd0);
      end
      // Seen high after edge ND+1, i.e. sampled high at edge ND+2.
      check_val("latency", 64'(e), 64'(ND + 1));
      check_val("product", out_product, expp);
      held = out_product;
      for (int h = 0; h < hold; h++) begin
         tick();
         check_val("hold_valid", 64'(out_valid), 64'd1);
         check_val("hold_prod", out_product, held);
         check_val("hold_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("ack_ready", 64'(in_ready), 64'd1);
      check_val("ack_valid", 64'(out_valid), 64'd0);
      check_val("ack_prod", out_product, 64'd0);
      n_txn++;
      $display("txn %0d: signed=%0d a=0x%h b=0x%h product=0x%h expected=0x%h",
               n_txn, s, a, b, held, expp);
   endtask

   task automatic reset_mid_run();
      bit ok;
      bit seen;
      wait_ready(ok);
      if (!ok) begin
         check_val("ready_timeout", 64'd0, 64'd1);
         return;
      end
      in_valid = 1'b1; in_a = 32'd99; in_b = 32'd77; in_signed = 1'b0;
      tick();                                   // edge 0
      in_valid = 1'b0;
      repeat (5) tick();                        // edges 1..5
      rst = 1'b1;
      tick();                                   // reset sampled at edge 6
      rst = 1'b0;
      check_val("rst_ready", 64'(in_ready), 64'd1);
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_prod", out_product, 64'd0);
      // Reset coinciding with a valid request must not start a transaction.
      rst = 1'b1; in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      check_val("rst_over_accept", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check_val("no_result", 64'(seen), 64'd0);
      $display("txn reset: transaction discarded, block idle");
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'hFFFF_FFFF;
      corners[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b0;
      @(negedge clk);
      repeat (3) tick();
      check_val("reset_ready", 64'(in_ready), 64'd1);
      check_val("reset_valid", 64'(out_valid), 64'd0);
      check_val("reset_prod", out_product, 64'd0);
      rst = 1'b0;
      tick();

      run_txn(32'd7, 32'd3, 1'b0, 0);
      run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_txn(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
      run_txn(32'hFFFF_FFFF, 32'd5, 1'b1, 0);
      run_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5);
      reset_mid_run();
      run_txn(32'd12, 32'd10, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         run_txn(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
